// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and helpers
// Purpose: default 640x480@60 timing numbers, line/frame total helpers and
//          colour field sizing used by the raster generator.
// Ports:   none (package).
package vga_pkg;

  // 640x480@60 Hz, 25 MHz pixel rate
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Colour is carried as {R,G,B}, each channel CW bits wide
  localparam int RGB_CHANNELS = 3;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int rgb_width(input int cw);
    return RGB_CHANNELS * cw;
  endfunction

endpackage

// File: rtl/vga_pix_ce.sv
// rtl/vga_pix_ce.sv - pixel-rate clock enable divider
// Purpose: produces a one-clk enable pulse every CLK_DIV system clocks.
//          The first pulse is seen at the CLK_DIVth clock edge after reset.
//          CLK_DIV=1 gives a permanently high enable.
// Ports:   i_clk    system clock
//          i_rst    async active-high reset
//          o_pix_ce pixel clock enable
module vga_pix_ce
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_pix_ce
);

  // At least one bit even for CLK_DIV=1, where the counter simply sits at 0
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div <= '0;
    end else if (r_div == LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign o_pix_ce = (r_div == LAST);

endmodule

// File: rtl/vga_timing_overlay.sv
// rtl/vga_timing_overlay.sv - parametrised VGA raster generator with one rectangle overlay
// Purpose: runs H/V counters at the pixel rate, emits registered syncs, active
//          video, pixel coordinates and a colour that is the rectangle colour
//          inside the rectangle and the background elsewhere in the active area.
// Ports:   clk, rst                     system clock, async active-high reset
//          rect_x0/x1, rect_y0/y1       rectangle bounds, inclusive
//          rect_rgb, bg_rgb             {R,G,B} rectangle / background colour
//          vga_hsy, vga_vsy             sync outputs (polarity HS_POL/VS_POL)
//          vga_red/green/blue           colour channels, zero while blanking
//          de, x, y                     active flag and coordinate of output pixel
//          frame_start                  one-clk pulse with output of pixel (0,0)
module vga_timing_overlay
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 1,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [XW-1:0]               rect_x0,
  input  logic [XW-1:0]               rect_x1,
  input  logic [YW-1:0]               rect_y0,
  input  logic [YW-1:0]               rect_y1,
  input  logic [rgb_width(CW)-1:0]    rect_rgb,
  input  logic [rgb_width(CW)-1:0]    bg_rgb,
  output logic                        vga_hsy,
  output logic                        vga_vsy,
  output logic [CW-1:0]               vga_red,
  output logic [CW-1:0]               vga_green,
  output logic [CW-1:0]               vga_blue,
  output logic                        de,
  output logic [XW-1:0]               x,
  output logic [YW-1:0]               y,
  output logic                        frame_start
);

  localparam int RGBW    = rgb_width(CW);
  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Decode constants carry one extra bit so a sync end equal to the total
  // (zero back porch) still fits without wrapping.
  localparam int XE = XW + 1;
  localparam int YE = YW + 1;

  localparam logic [XW-1:0] H_LAST  = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST  = YW'(V_TOTAL - 1);
  localparam logic [XE-1:0] H_ACT_E = XE'(H_ACTIVE);
  localparam logic [XE-1:0] H_SS_E  = XE'(H_ACTIVE + H_FP);
  localparam logic [XE-1:0] H_SE_E  = XE'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YE-1:0] V_ACT_E = YE'(V_ACTIVE);
  localparam logic [YE-1:0] V_SS_E  = YE'(V_ACTIVE + V_FP);
  localparam logic [YE-1:0] V_SE_E  = YE'(V_ACTIVE + V_FP + V_SYNC);

  logic w_ce;

  vga_pix_ce #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_ce (
    .i_clk    (clk),
    .i_rst    (rst),
    .o_pix_ce (w_ce)
  );

  // Raster counters
  logic [XW-1:0] r_h;
  logic [YW-1:0] r_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_ce) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  // Shadow copies of the overlay controls, refreshed once per frame
  logic [XW-1:0]   r_x0, r_x1;
  logic [YW-1:0]   r_y0, r_y1;
  logic [RGBW-1:0] r_rect_rgb, r_bg_rgb;

  logic w_first;
  assign w_first = (r_h == '0) && (r_v == '0);

  // Pixel (0,0) is rendered with the values being captured on that same
  // edge, so every pixel of a frame sees one consistent set of controls.
  logic [XW-1:0]   w_x0, w_x1;
  logic [YW-1:0]   w_y0, w_y1;
  logic [RGBW-1:0] w_rect_rgb, w_bg_rgb;

  assign w_x0       = w_first ? rect_x0  : r_x0;
  assign w_x1       = w_first ? rect_x1  : r_x1;
  assign w_y0       = w_first ? rect_y0  : r_y0;
  assign w_y1       = w_first ? rect_y1  : r_y1;
  assign w_rect_rgb = w_first ? rect_rgb : r_rect_rgb;
  assign w_bg_rgb   = w_first ? bg_rgb   : r_bg_rgb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x0       <= '0;
      r_x1       <= '0;
      r_y0       <= '0;
      r_y1       <= '0;
      r_rect_rgb <= '0;
      r_bg_rgb   <= '0;
    end else if (w_ce && w_first) begin
      r_x0       <= rect_x0;
      r_x1       <= rect_x1;
      r_y0       <= rect_y0;
      r_y1       <= rect_y1;
      r_rect_rgb <= rect_rgb;
      r_bg_rgb   <= bg_rgb;
    end
  end

  // Decode for the current counter position
  logic [XE-1:0]   w_h_e;
  logic [YE-1:0]   w_v_e;
  logic            w_de, w_hs_on, w_vs_on, w_in_rect;
  logic [RGBW-1:0] w_rgb;

  assign w_h_e     = {1'b0, r_h};
  assign w_v_e     = {1'b0, r_v};
  assign w_de      = (w_h_e < H_ACT_E) && (w_v_e < V_ACT_E);
  assign w_hs_on   = (w_h_e >= H_SS_E) && (w_h_e < H_SE_E);
  assign w_vs_on   = (w_v_e >= V_SS_E) && (w_v_e < V_SE_E);
  // Inverted bounds make this false everywhere, giving an empty rectangle
  assign w_in_rect = (r_h >= w_x0) && (r_h <= w_x1) && (r_v >= w_y0) && (r_v <= w_y1);
  assign w_rgb     = !w_de ? '0 : (w_in_rect ? w_rect_rgb : w_bg_rgb);

  // Output registers, one pixel period behind the counters
  logic            r_hsy, r_vsy, r_de, r_fs;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [RGBW-1:0] r_rgb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsy <= ~HS_POL;
      r_vsy <= ~VS_POL;
      r_de  <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
      r_rgb <= '0;
      r_fs  <= 1'b0;
    end else begin
      r_fs <= w_ce && w_first;
      if (w_ce) begin
        r_hsy <= w_hs_on ? HS_POL : ~HS_POL;
        r_vsy <= w_vs_on ? VS_POL : ~VS_POL;
        r_de  <= w_de;
        r_x   <= r_h;
        r_y   <= r_v;
        r_rgb <= w_rgb;
      end
    end
  end

  assign vga_hsy     = r_hsy;
  assign vga_vsy     = r_vsy;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign frame_start = r_fs;
  assign vga_red     = r_rgb[3*CW-1:2*CW];
  assign vga_green   = r_rgb[2*CW-1:CW];
  assign vga_blue    = r_rgb[CW-1:0];

endmodule
